seven_seg_mux: RTL and testbench

- Parametrised, time-multiplexed driver for an N-digit hex seven-segment display.
- Successor to the fixed 4-digit driver, adding:
  - a refresh prescaler
  - tear-free frame-synchronous data loading
  - per-digit decimal points and blanking
  - leading-zero suppression
  - PWM brightness
  - selectable output polarity
- Sits between CPU output/debug registers and the board display pins.

---
 rtl/seven_seg_pkg.sv | 18 +
 rtl/seven_seg_decode.sv | 13 +
 rtl/seven_seg_mux.sv | 165 ++++++++++++++++
 tb/tb_seven_seg_mux.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment display driver.
//   SEG_W   : segment bus width (g..a)
//   SEG_OFF : active-high "all segments dark" pattern
//   FONT    : active-high hex font, index = nibble value, bit 6 = g ... bit 0 = a
package seven_seg_pkg;

  localparam int SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_OFF = '0;

  localparam logic [SEG_W-1:0] FONT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational hex nibble to seven-segment pattern (active-high, g..a).
//   nibble : hex digit value 0..F
//   seg    : segment pattern, bit 6 = g ... bit 0 = a
module seven_seg_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0]       nibble,
  output logic [SEG_W-1:0] seg
);

  assign seg = FONT[nibble];

endmodule

// File: rtl/seven_seg_mux.sv
// Time-multiplexed N-digit hex seven-segment display driver.
// A free-running prescaler divides clk into digit slots of 2**DIV_W cycles.
// New display content is staged on load and only copied into the shadow
// registers at the end of a full frame, so a frame never mixes old and new
// digits. The display path adds per-digit blanking, decimal points,
// leading-zero suppression and PWM brightness; polarity is applied at the
// output registers.
//   clk        : system clock
//   reset      : asynchronous active-low reset
//   data       : hex nibbles, digit i = data[4i+3:4i], digit 0 rightmost
//   dp_in      : decimal point request per digit (1 = lit)
//   blank      : force digit dark (1 = blank)
//   load       : capture data/dp_in/blank into staging
//   lz_en      : leading-zero suppression enable (live)
//   brightness : PWM duty level, all ones = full on, 0 = dark
//   pending    : staged content waiting for the frame boundary
//   g_to_a     : segment pins g..a
//   dp         : decimal point pin
//   an         : digit enable pins
module seven_seg_mux
  import seven_seg_pkg::*;
#(
  parameter int N_DIGITS   = 4,
  parameter int DIV_W      = 16,
  parameter int BRIGHT_W   = 3,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*N_DIGITS-1:0] data,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   blank,
  input  logic                  load,
  input  logic                  lz_en,
  input  logic [BRIGHT_W-1:0]   brightness,
  output logic                  pending,
  output logic [SEG_W-1:0]      g_to_a,
  output logic                  dp,
  output logic [N_DIGITS-1:0]   an
);

  localparam int SW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [SW-1:0] LAST = SW'(N_DIGITS - 1);

  // XOR masks that turn an active-high value into the pin level.
  localparam logic [N_DIGITS-1:0] AN_POL  = {N_DIGITS{ACTIVE_LOW}};
  localparam logic [SEG_W-1:0]    SEG_POL = {SEG_W{ACTIVE_LOW}};

  logic [DIV_W-1:0] cnt;
  logic [SW-1:0]    s;
  logic             tick;
  logic             frame_end;

  logic [4*N_DIGITS-1:0] stg_data, shd_data;
  logic [N_DIGITS-1:0]   stg_dp, shd_dp;
  logic [N_DIGITS-1:0]   stg_blank, shd_blank;

  logic [N_DIGITS-1:0] supp;
  logic [N_DIGITS-1:0] sel;
  logic                zero_run;
  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                cur_blank;
  logic                cur_supp;
  logic                pwm_off;
  logic                dark;
  logic [SEG_W-1:0]    font_seg;

  assign tick      = &cnt;
  assign frame_end = tick && (s == LAST);

  // Prescaler and digit index. The explicit wrap at LAST keeps a
  // non-power-of-two digit count from ever reaching an unused index.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      s   <= '0;
    end else begin
      cnt <= cnt + 1'b1;
      if (tick) begin
        s <= (s == LAST) ? '0 : s + 1'b1;
      end
    end
  end

  // Staging captures every load; the shadow only moves on a frame boundary.
  // On a load/frame_end collision the shadow takes the old staging value
  // and the freshly loaded one stays pending for the next frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stg_data  <= '0;
      stg_dp    <= '0;
      stg_blank <= '0;
      shd_data  <= '0;
      shd_dp    <= '0;
      shd_blank <= '0;
      pending   <= 1'b0;
    end else begin
      if (frame_end && pending) begin
        shd_data  <= stg_data;
        shd_dp    <= stg_dp;
        shd_blank <= stg_blank;
      end
      if (load) begin
        stg_data  <= data;
        stg_dp    <= dp_in;
        stg_blank <= blank;
        pending   <= 1'b1;
      end else if (frame_end) begin
        pending   <= 1'b0;
      end
    end
  end

  // Digit i is suppressed when it and every digit to its left are zero;
  // digit 0 is always shown so an all-zero value still reads "0".
  always_comb begin
    supp     = '0;
    zero_run = 1'b1;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (shd_data[4*i +: 4] == 4'h0);
      supp[i]  = lz_en && zero_run && (i > 0);
    end
  end

  always_comb begin
    sel       = '0;
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    cur_supp  = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (s == SW'(i)) begin
        sel[i]    = 1'b1;
        cur_nib   = shd_data[4*i +: 4];
        cur_dp    = shd_dp[i];
        cur_blank = shd_blank[i];
        cur_supp  = supp[i];
      end
    end
  end

  // PWM compares the top prescaler bits against the duty level, so each
  // slot is lit for the first brightness/2**BRIGHT_W of its length.
  assign pwm_off = (brightness != '1) && (cnt[DIV_W-1 -: BRIGHT_W] >= brightness);
  assign dark    = cur_blank || cur_supp || pwm_off;

  seven_seg_decode u_decode (
    .nibble (cur_nib),
    .seg    (font_seg)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an     <= AN_POL;
      g_to_a <= SEG_POL;
      dp     <= ACTIVE_LOW;
    end else begin
      an     <= (dark ? '0 : sel) ^ AN_POL;
      g_to_a <= (dark ? SEG_OFF : font_seg) ^ SEG_POL;
      dp     <= (dark ? 1'b0 : cur_dp) ^ ACTIVE_LOW;
    end
  end

endmodule

// File: tb/tb_seven_seg_mux.sv
// Bench for seven_seg_mux: a 4-digit active-low instance and a 6-digit
// active-high instance share clock, reset and control; a cycle-count based
// reference model predicts every pin of both every cycle.
module tb_seven_seg_mux;

  logic        clk;
  logic        reset;
  logic        load;
  logic        lz_en;
  logic [2:0]  brightness;

  logic [15:0] data_a;
  logic [3:0]  dpi_a, bl_a, an_a;
  logic [6:0]  seg_a;
  logic        dp_a, pend_a;

  logic [23:0] data_b;
  logic [5:0]  dpi_b, bl_b, an_b;
  logic [6:0]  seg_b;
  logic        dp_b, pend_b;

  int n_cmp = 0;
  int n_mis = 0;
  int k     = 0;
  bit chk_en = 1'b0;

  seven_seg_mux #(.N_DIGITS(4), .DIV_W(4), .BRIGHT_W(3), .ACTIVE_LOW(1'b1)) dut_a (
    .clk(clk), .reset(reset), .data(data_a), .dp_in(dpi_a), .blank(bl_a),
    .load(load), .lz_en(lz_en), .brightness(brightness),
    .pending(pend_a), .g_to_a(seg_a), .dp(dp_a), .an(an_a)
  );

  seven_seg_mux #(.N_DIGITS(6), .DIV_W(4), .BRIGHT_W(3), .ACTIVE_LOW(1'b0)) dut_b (
    .clk(clk), .reset(reset), .data(data_b), .dp_in(dpi_b), .blank(bl_b),
    .load(load), .lz_en(lz_en), .brightness(brightness),
    .pending(pend_b), .g_to_a(seg_b), .dp(dp_b), .an(an_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  localparam logic [6:0] FONT_M [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  localparam int NDIG [2] = '{4, 6};
  localparam bit ALOW [2] = '{1'b1, 1'b0};

  logic [31:0] in_d [2];
  logic [7:0]  in_dp [2];
  logic [7:0]  in_bl [2];
  always_comb begin
    in_d[0]  = {16'h0, data_a};
    in_d[1]  = {8'h0, data_b};
    in_dp[0] = {4'h0, dpi_a};
    in_dp[1] = {2'h0, dpi_b};
    in_bl[0] = {4'h0, bl_a};
    in_bl[1] = {2'h0, bl_b};
  end

  logic [31:0] sh_d [2], st_d [2];
  logic [7:0]  sh_dp [2], st_dp [2], sh_bl [2], st_bl [2];
  logic        pend_m [2];
  logic [15:0] e_out [2];
  int          cyc;

  // Pin values for cycle cy, from the display rules: slot = cy/16 mod n,
  // position inside the slot = cy mod 16.
  function automatic logic [15:0] pins(input int n, input bit al, input logic [31:0] sd,
                                       input logic [7:0] sdp, input logic [7:0] sbl,
                                       input bit lz, input logic [2:0] br, input int cy);
    int         slot;
    int         c;
    logic [3:0] nib;
    bit         dark;
    logic [7:0] an;
    logic [6:0] seg;
    logic       d;
    logic [7:0] mask;
    slot = (cy / 16) % n;
    c    = cy % 16;
    nib  = sd[slot*4 +: 4];
    dark = sbl[slot] || (lz && slot > 0 && (sd >> (4*slot)) == 32'h0) ||
           (br != 3'd7 && (c / 2) >= int'(br));
    mask = 8'((1 << n) - 1);
    an   = dark ? 8'h00 : 8'(1 << slot);
    seg  = dark ? 7'h00 : FONT_M[nib];
    d    = dark ? 1'b0 : sdp[slot];
    if (al) begin
      an  = ~an & mask;
      seg = ~seg;
      d   = ~d;
    end
    return {an, seg, d};
  endfunction

  function automatic bit fe_at(input int n, input int cy);
    return (cy % (16*n)) == (16*n - 1);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc <= 0;
      for (int j = 0; j < 2; j++) begin
        sh_d[j] <= '0;  st_d[j] <= '0;
        sh_dp[j] <= '0; st_dp[j] <= '0;
        sh_bl[j] <= '0; st_bl[j] <= '0;
        pend_m[j] <= 1'b0;
      end
      e_out[0] <= {8'h0F, 7'h7F, 1'b1};
      e_out[1] <= 16'h0000;
    end else begin
      for (int j = 0; j < 2; j++) begin
        e_out[j] <= pins(NDIG[j], ALOW[j], sh_d[j], sh_dp[j], sh_bl[j], lz_en, brightness, cyc);
        if (fe_at(NDIG[j], cyc) && pend_m[j]) begin
          sh_d[j]  <= st_d[j];
          sh_dp[j] <= st_dp[j];
          sh_bl[j] <= st_bl[j];
        end
        if (load) begin
          st_d[j]  <= in_d[j];
          st_dp[j] <= in_dp[j];
          st_bl[j] <= in_bl[j];
        end
        pend_m[j] <= load || (pend_m[j] && !fe_at(NDIG[j], cyc));
      end
      cyc <= cyc + 1;
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      n_cmp++;
      if ({4'h0, an_a, seg_a, dp_a, pend_a} != {e_out[0], pend_m[0]}) begin
        n_mis++;
        $display("FAIL pins_a t=%0t got an=%b seg=%h dp=%b pend=%b want an=%b seg=%h dp=%b pend=%b",
                 $time, an_a, seg_a, dp_a, pend_a, e_out[0][11:8], e_out[0][7:1], e_out[0][0], pend_m[0]);
      end
      n_cmp++;
      if ({2'h0, an_b, seg_b, dp_b, pend_b} != {e_out[1], pend_m[1]}) begin
        n_mis++;
        $display("FAIL pins_b t=%0t got an=%b seg=%h dp=%b pend=%b want an=%b seg=%h dp=%b pend=%b",
                 $time, an_b, seg_b, dp_b, pend_b, e_out[1][13:8], e_out[1][7:1], e_out[1][0], pend_m[1]);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s at k=%0d got %h want %h", nm, k, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  task automatic goto(input int t);
    while (k < t) step(1);
  endtask

  task automatic do_load();
    load = 1'b1;
    step(1);
    load = 1'b0;
  endtask

  task automatic lit_count(input logic [2:0] br, input int want, input string nm);
    int lit;
    lit = 0;
    brightness = br;
    repeat (16) begin
      step(1);
      if (an_a != 4'hF) lit++;
    end
    chk(nm, 32'(lit), 32'(want));
  endtask

  task automatic rnd_run(input int n);
    repeat (n) begin
      if ($urandom_range(0, 19) == 0) begin
        data_a = 16'($urandom());
        data_b = 24'($urandom());
        if ($urandom_range(0, 2) == 0) begin
          data_a = data_a & 16'h00FF;
          data_b = data_b & 24'h000F0F;
        end
        dpi_a = 4'($urandom());
        dpi_b = 6'($urandom());
        bl_a  = 4'($urandom()) & 4'($urandom());
        bl_b  = 6'($urandom()) & 6'($urandom());
        load  = 1'b1;
      end else begin
        load  = 1'b0;
      end
      if ($urandom_range(0, 49) == 0) lz_en = 1'($urandom());
      if ($urandom_range(0, 59) == 0)
        brightness = ($urandom_range(0, 1) == 0) ? 3'd7 : 3'($urandom_range(0, 7));
      step(1);
    end
    load = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0; load = 1'b0; lz_en = 1'b0; brightness = 3'd7;
    data_a = '0; dpi_a = '0; bl_a = '0;
    data_b = '0; dpi_b = '0; bl_b = '0;

    step(1);
    chk_en = 1'b1;
    step(2);
    chk("rst_an_a",   32'(an_a),   32'h0F);
    chk("rst_seg_a",  32'(seg_a),  32'h7F);
    chk("rst_dp_a",   32'(dp_a),   32'h1);
    chk("rst_pend_a", 32'(pend_a), 32'h0);
    chk("rst_an_b",   32'(an_b),   32'h00);
    chk("rst_seg_b",  32'(seg_b),  32'h00);

    reset = 1'b1;
    k = 0;
    step(1);
    chk("first_an",  32'(an_a),  32'b1110);
    chk("first_seg", 32'(seg_a), 32'h40);
    goto(17);
    chk("slot1_an", 32'(an_a), 32'b1101);

    data_a = 16'h12AF; data_b = 24'($urandom());
    do_load();
    chk("load_pend", 32'(pend_a), 32'h1);
    goto(63);
    chk("held_pend", 32'(pend_a), 32'h1);
    chk("held_seg",  32'(seg_a),  32'h40);
    goto(65);
    chk("newF_seg",  32'(seg_a),  32'h0E);
    chk("newF_an",   32'(an_a),   32'b1110);
    chk("newF_pend", 32'(pend_a), 32'h0);
    goto(81);
    chk("newA_seg", 32'(seg_a), 32'h08);

    goto(99);  data_a = 16'h1111; do_load();
    goto(109); data_a = 16'h2222; do_load();
    goto(129);
    chk("lastwin_seg", 32'(seg_a), 32'h24);

    goto(149); data_a = 16'h3333; do_load();
    goto(191); data_a = 16'h4444; do_load();
    chk("coll_pend", 32'(pend_a), 32'h1);
    goto(193);
    chk("coll_old_seg", 32'(seg_a),  32'h30);
    chk("coll_pend2",   32'(pend_a), 32'h1);
    goto(257);
    chk("coll_new_seg", 32'(seg_a),  32'h19);
    chk("coll_pend3",   32'(pend_a), 32'h0);

    lz_en = 1'b1;
    goto(259); data_a = 16'h0040; do_load();
    goto(321);
    chk("lz_d0_an",  32'(an_a),  32'b1110);
    chk("lz_d0_seg", 32'(seg_a), 32'h40);
    goto(337);
    chk("lz_d1_an",  32'(an_a),  32'b1101);
    chk("lz_d1_seg", 32'(seg_a), 32'h19);
    goto(353);
    chk("lz_d2_an",  32'(an_a),  32'hF);
    chk("lz_d2_seg", 32'(seg_a), 32'h7F);
    goto(369);
    chk("lz_d3_an", 32'(an_a), 32'hF);
    data_a = 16'h0000; do_load();
    goto(385);
    chk("lz0_d0_an",  32'(an_a),  32'b1110);
    chk("lz0_d0_seg", 32'(seg_a), 32'h40);
    goto(401);
    chk("lz0_d1_an", 32'(an_a), 32'hF);

    goto(448); lit_count(3'b010, 4,  "bright2_lit");
    goto(512); lit_count(3'b111, 16, "bright7_lit");
    goto(576); lit_count(3'b000, 0,  "bright0_lit");
    brightness = 3'd7;
    lz_en = 1'b0;

    goto(599);
    data_a = 16'($urandom()); bl_a = '0; dpi_a = '0;
    data_b = 24'($urandom()); bl_b = 6'b000100; dpi_b = 6'b000001;
    do_load();
    goto(673);
    chk("geo_d0_an", 32'(an_b), 32'b000001);
    chk("geo_d0_dp", 32'(dp_b), 32'h1);
    goto(705);
    chk("geo_d2_an", 32'(an_b), 32'h00);

    rnd_run(800);

    data_a = 16'hBEEF; data_b = 24'hC0FFEE;
    do_load();
    step(5);
    reset = 1'b0;
    step(2);
    chk("midrst_pend_a", 32'(pend_a), 32'h0);
    chk("midrst_an_a",   32'(an_a),   32'hF);
    chk("midrst_pend_b", 32'(pend_b), 32'h0);
    reset = 1'b1;
    rnd_run(400);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
